regf_arb: RTL and testbench
===========================

REGF_ARB -- requirements
Module: regf_arb

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: ADDR_W, 4, register address width.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 Port: req_valid0, req_valid1  in  1  requester 0/1 transaction request.
REQ-006 Port: req_ready0, req_ready1  out  1  requester 0/1 accept; handshake = valid & ready at posedge.
REQ-007 Port: req_we0, req_we1  in  1  transaction includes a write.
REQ-008 Port: req_ra1_0, req_ra2_0, req_ra1_1, req_ra2_1  in  ADDR_W  read addresses.
REQ-009 Port: req_wa0, req_wa1  in  ADDR_W  write address.
REQ-010 Port: req_wd0, req_wd1  in  DATA_W  write data.
REQ-011 Port: rsp_valid0, rsp_valid1  out  1  read response valid.
REQ-012 Port: rsp_ready0, rsp_ready1  in  1  requester accepts response.
REQ-013 Port: rsp_rd1, rsp_rd2  out  DATA_W  response data, shared; meaningful only while a rsp_valid is high.
REQ-014 Port: rf_A1, rf_A2, rf_A3  out  ADDR_W  to register file read/write address ports.
REQ-015 Port: rf_we3  out  1  register file write enable.
REQ-016 Port: rf_WD3  out  DATA_W  register file write data.
REQ-017 Port: rf_RD1, rf_RD2  in  DATA_W  register file read data; register file registers reads, valid one cycle after address is sampled.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP; IDLE->ISSUE on handshake, ISSUE->CAPTURE and CAPTURE->RESP unconditionally, RESP->IDLE on rsp_valid & rsp_ready of the granted requester.
REQ-019 In IDLE, req_readyN SHALL be asserted combinationally only for the granted requester; in all other states both req_ready are 0.
REQ-020 Arbitration SHALL be round-robin: one valid requester is granted; both valid grants the requester not granted last; last_grant updates only on handshake.
REQ-021 On handshake, ra1, ra2, wa, wd, we and grant ID SHALL be latched; requester inputs are ignored until the next IDLE.
REQ-022 In ISSUE only, rf_A1/rf_A2/rf_A3/rf_WD3 SHALL drive latched values and rf_we3 = latched we; rf_we3 is 0 in every other state.
REQ-023 Read data SHALL be pre-write values: a transaction reading its own write address returns the old value.
REQ-024 In CAPTURE, rf_RD1/rf_RD2 SHALL be registered into rsp_rd1/rsp_rd2; rsp_validN rises first cycle of RESP (3 cycles after the accept edge).
REQ-025 rsp_rd1/rsp_rd2 and rsp_validN SHALL hold stable in RESP until rsp_readyN; the next accept can occur no earlier than the cycle after RESP exits (peak throughput 1 transaction / 4 cycles).
REQ-026 rsp_ready of the non-granted requester SHALL be ignored.
REQ-027 rf_A1/rf_A2/rf_A3/rf_WD3 SHALL hold their last ISSUE values outside ISSUE.

Reset
REQ-028 With rst_n low at a posedge, state SHALL go to IDLE, last_grant to 1 (requester 0 wins first tie), latched request and rsp_rd1/rsp_rd2 to 0, all rf_* outputs to 0.
REQ-029 During reset rsp_valid0/1, req_ready0/1 and rf_we3 SHALL be 0; an in-flight transaction SHALL be dropped with no write issued after reset asserts.

Configuration
REQ-030 Macro REGF_ARB_ZERO_REG_EN defined: a latched write with wa = 0 SHALL drive rf_we3 = 0 in ISSUE, and a read of address 0 SHALL return 0 in rsp_rd1/rsp_rd2 regardless of rf_RD1/rf_RD2.
REQ-031 Macro REGF_ARB_ZERO_REG_EN undefined: address 0 SHALL be treated as any other register (writes and reads pass through).

Verification
REQ-032 Single req0 we=1, wa=5, wd=0xDEADBEEF, ra1=5: rf_we3 high exactly one cycle with rf_A3=5; rsp_valid0 3 cycles after accept; rsp_rd1 = prior value of reg 5.
REQ-033 req_valid0 and req_valid1 high from reset for 3 transactions each, rsp_ready tied 1: grants alternate 0,1,0,1,0,1.
REQ-034 rsp_ready0 held low 5 cycles in RESP: rsp_valid0 and rsp_rd1/rsp_rd2 stable, req_ready0/1 stay 0, no rf_we3 pulse.
REQ-035 rst_n low during CAPTURE of a we=1 transaction: next cycle IDLE, rsp_valid0 never asserts, no further rf_we3.
REQ-036 With REGF_ARB_ZERO_REG_EN: we=1, wa=0, wd=0x1234, ra1=0 with rf_RD1 forced 0xFFFFFFFF: rf_we3 stays 0, rsp_rd1 = 0; without macro: rf_we3 pulses, rsp_rd1 = 0xFFFFFFFF.

Source files
------------

// File: rtl/regf_arb_if.sv
// Requester-side bundle for regf_arb: two request/response channels
// sharing one response data bus.
interface regf_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req_valid0;
  logic              req_valid1;
  logic              req_ready0;
  logic              req_ready1;
  logic              req_we0;
  logic              req_we1;
  logic [ADDR_W-1:0] req_ra1_0;
  logic [ADDR_W-1:0] req_ra2_0;
  logic [ADDR_W-1:0] req_ra1_1;
  logic [ADDR_W-1:0] req_ra2_1;
  logic [ADDR_W-1:0] req_wa0;
  logic [ADDR_W-1:0] req_wa1;
  logic [DATA_W-1:0] req_wd0;
  logic [DATA_W-1:0] req_wd1;
  logic              rsp_valid0;
  logic              rsp_valid1;
  logic              rsp_ready0;
  logic              rsp_ready1;
  logic [DATA_W-1:0] rsp_rd1;
  logic [DATA_W-1:0] rsp_rd2;

  modport master (
    output req_valid0, req_valid1,
    input  req_ready0, req_ready1,
    output req_we0, req_we1,
    output req_ra1_0, req_ra2_0,
    output req_ra1_1, req_ra2_1,
    output req_wa0, req_wa1,
    output req_wd0, req_wd1,
    input  rsp_valid0, rsp_valid1,
    output rsp_ready0, rsp_ready1,
    input  rsp_rd1, rsp_rd2
  );

  modport slave (
    input  req_valid0, req_valid1,
    output req_ready0, req_ready1,
    input  req_we0, req_we1,
    input  req_ra1_0, req_ra2_0,
    input  req_ra1_1, req_ra2_1,
    input  req_wa0, req_wa1,
    input  req_wd0, req_wd1,
    output rsp_valid0, rsp_valid1,
    input  rsp_ready0, rsp_ready1,
    output rsp_rd1, rsp_rd2
  );
endinterface

// File: rtl/regf_arb.sv
// Two-requester round-robin arbiter in front of a registered-read regfile.
// Optional REGF_ARB_ZERO_REG_EN makes register 0 read as 0 and ignore writes.
module regf_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  regf_arb_if.slave         bus,
  output logic [ADDR_W-1:0] rf_A1,
  output logic [ADDR_W-1:0] rf_A2,
  output logic [ADDR_W-1:0] rf_A3,
  output logic              rf_we3,
  output logic [DATA_W-1:0] rf_WD3,
  input  logic [DATA_W-1:0] rf_RD1,
  input  logic [DATA_W-1:0] rf_RD2
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic              last_grant;
  logic              gid;
  logic              we;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  logic any_req;
  logic pick;
  logic accept;
  logic rsp_done;
  logic wr_ok;
  logic zero1;
  logic zero2;

  // Tie goes to whoever was not served last.
  always_comb begin
    any_req = bus.req_valid0 | bus.req_valid1;
    pick    = bus.req_valid1;
    if (bus.req_valid0 && bus.req_valid1)
      pick = ~last_grant;
  end

  always_comb begin
    state_nx       = state;
    bus.req_ready0 = 1'b0;
    bus.req_ready1 = 1'b0;
    accept         = 1'b0;
    rsp_done       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready0 = rst_n & any_req & ~pick;
        bus.req_ready1 = rst_n & any_req & pick;
        accept = (bus.req_valid0 & bus.req_ready0)
               | (bus.req_valid1 & bus.req_ready1);
        if (accept)
          state_nx = ISSUE;
      end
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP: begin
        rsp_done = gid ? bus.rsp_ready1
                       : bus.rsp_ready0;
        if (rsp_done)
          state_nx = IDLE;
      end
    endcase
  end

`ifdef REGF_ARB_ZERO_REG_EN
  assign wr_ok = we & (wa != '0);
  assign zero1 = (ra1 == '0);
  assign zero2 = (ra2 == '0);
`else
  assign wr_ok = we;
  assign zero1 = 1'b0;
  assign zero2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gid        <= 1'b0;
      we         <= 1'b0;
      ra1        <= '0;
      ra2        <= '0;
      wa         <= '0;
      wd         <= '0;
      rd1        <= '0;
      rd2        <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant <= pick;
        gid        <= pick;
        we  <= pick ? bus.req_we1 : bus.req_we0;
        ra1 <= pick ? bus.req_ra1_1
                    : bus.req_ra1_0;
        ra2 <= pick ? bus.req_ra2_1
                    : bus.req_ra2_0;
        wa  <= pick ? bus.req_wa1 : bus.req_wa0;
        wd  <= pick ? bus.req_wd1 : bus.req_wd0;
      end
      if (state == CAPTURE) begin
        rd1 <= zero1 ? '0 : rf_RD1;
        rd2 <= zero2 ? '0 : rf_RD2;
      end
    end
  end

  // Latched fields only change on accept, so the
  // rf address/data ports hold between issues.
  assign rf_A1  = ra1;
  assign rf_A2  = ra2;
  assign rf_A3  = wa;
  assign rf_WD3 = wd;
  assign rf_we3 = rst_n & (state == ISSUE)
                & wr_ok;

  assign bus.rsp_valid0 = rst_n & (state == RESP)
                        & ~gid;
  assign bus.rsp_valid1 = rst_n & (state == RESP)
                        & gid;
  assign bus.rsp_rd1 = rd1;
  assign bus.rsp_rd2 = rd2;

endmodule

// File: tb/tb_regf_arb.sv
// Directed scoreboard bench for regf_arb with a read-first
// registered regfile model behind it.
module tb_regf_arb;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef REGF_ARB_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef struct {
    bit          g;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rf_A1, rf_A2, rf_A3;
  logic          rf_we3;
  logic [DW-1:0] rf_WD3, rf_RD1, rf_RD2;

  regf_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regf_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .rf_A1  (rf_A1),
    .rf_A2  (rf_A2),
    .rf_A3  (rf_A3),
    .rf_we3 (rf_we3),
    .rf_WD3 (rf_WD3),
    .rf_RD1 (rf_RD1),
    .rf_RD2 (rf_RD2)
  );

  logic [31:0] mem [16];
  logic [31:0] sh [16];
  logic [31:0] q1, q2;
  logic        mem_init;
  logic        force_rd1;
  int          we_cnt = 0;
  int          rv0_cnt = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sbq [$];

  function automatic logic [31:0] init_val(input int i);
    return 32'h0A0B_0C00 + i * 32'h0001_0001;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= init_val(i);
    end else begin
      q1 <= mem[rf_A1];
      q2 <= mem[rf_A2];
      if (rf_we3)
        mem[rf_A3] <= rf_WD3;
    end
  end

  assign rf_RD1 = force_rd1 ? 32'hFFFF_FFFF : q1;
  assign rf_RD2 = q2;

  always @(posedge clk) begin
    if (rf_we3)
      we_cnt <= we_cnt + 1;
    if (bus.rsp_valid0)
      rv0_cnt <= rv0_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input bit g, input bit we,
                       input logic [3:0] wa,
                       input logic [31:0] wd,
                       input logic [3:0] a1,
                       input logic [3:0] a2);
    if (!g) begin
      bus.req_we0 = we; bus.req_wa0 = wa;
      bus.req_wd0 = wd; bus.req_ra1_0 = a1;
      bus.req_ra2_0 = a2;
    end else begin
      bus.req_we1 = we; bus.req_wa1 = wa;
      bus.req_wd1 = wd; bus.req_ra1_1 = a1;
      bus.req_ra2_1 = a2;
    end
  endtask

  function automatic logic [31:0] rd_exp(
      input logic [3:0] a, input bit frc);
    if (ZERO_EN && a == 4'd0) return 32'd0;
    if (frc) return 32'hFFFF_FFFF;
    return sh[a];
  endfunction

  // Called at the negedge before the accepting posedge.
  task automatic accepted(input bit g);
    exp_t e;
    logic we;
    logic [3:0] wa, a1, a2;
    logic [31:0] wd;
    we = g ? bus.req_we1 : bus.req_we0;
    wa = g ? bus.req_wa1 : bus.req_wa0;
    wd = g ? bus.req_wd1 : bus.req_wd0;
    a1 = g ? bus.req_ra1_1 : bus.req_ra1_0;
    a2 = g ? bus.req_ra2_1 : bus.req_ra2_0;
    e.g  = g;
    e.d1 = rd_exp(a1, force_rd1);
    e.d2 = rd_exp(a2, 1'b0);
    sbq.push_back(e);
    if (we && !(ZERO_EN && wa == 4'd0))
      sh[wa] = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input bit g, input bit we,
                       input logic [3:0] wa,
                       input logic [31:0] wd,
                       input logic [3:0] a1,
                       input logic [3:0] a2);
    bit ok;
    @(negedge clk);
    drive(g, we, wa, wd, a1, a2);
    if (g) bus.req_valid1 = 1'b1;
    else   bus.req_valid0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((g ? bus.req_ready1 : bus.req_ready0)
          === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("ready_timeout",
          g ? bus.req_ready1 : bus.req_ready0, 1);
      bus.req_valid0 = 1'b0;
      bus.req_valid1 = 1'b0;
      return;
    end
    accepted(g);
    bus.req_valid0 = 1'b0;
    bus.req_valid1 = 1'b0;
    #1;
  endtask

  task automatic collect();
    exp_t e;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ((bus.rsp_valid0 | bus.rsp_valid1)
          === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!got) begin
      chk("rsp_timeout",
          bus.rsp_valid0 | bus.rsp_valid1, 1);
      return;
    end
    if (sbq.size() == 0) begin
      chk("rsp_unexpected", bus.rsp_valid0
          | bus.rsp_valid1, 0);
      return;
    end
    e = sbq.pop_front();
    chk("rsp_gid", {31'd0, bus.rsp_valid1},
        {31'd0, e.g});
    chk("rsp_rd1", bus.rsp_rd1, e.d1);
    chk("rsp_rd2", bus.rsp_rd2, e.d2);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int w0, r0, n0, n1;
    bit g;
    for (int i = 0; i < 16; i++)
      sh[i] = init_val(i);
    force_rd1 = 1'b0;
    mem_init = 1'b1;
    rst_n = 1'b0;
    bus.req_valid0 = 1'b1;
    bus.req_valid1 = 1'b0;
    bus.rsp_ready0 = 1'b1;
    bus.rsp_ready1 = 1'b1;
    drive(0, 1, 4'd3, 32'h55, 4'd1, 4'd2);
    drive(1, 0, 4'd0, 32'h0, 4'd0, 4'd0);

    // reset values, requester 0 already waiting
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ready0", bus.req_ready0, 0);
    chk("rst_ready1", bus.req_ready1, 0);
    chk("rst_rsp_valid0", bus.rsp_valid0, 0);
    chk("rst_rsp_valid1", bus.rsp_valid1, 0);
    chk("rst_we3", rf_we3, 0);
    chk("rst_A1", rf_A1, 0);
    chk("rst_A3", rf_A3, 0);
    chk("rst_WD3", rf_WD3, 0);
    chk("rst_rd1", bus.rsp_rd1, 0);
    bus.req_valid0 = 1'b0;
    rst_n = 1'b1;

    // single write+read-own-address transaction
    w0 = we_cnt;
    issue(0, 1, 4'd5, 32'hDEAD_BEEF, 4'd5, 4'd3);
    chk("iss_we3", rf_we3, 1);
    chk("iss_A3", rf_A3, 5);
    chk("iss_A1", rf_A1, 5);
    chk("iss_WD3", rf_WD3, 32'hDEAD_BEEF);
    chk("iss_rv0", bus.rsp_valid0, 0);
    @(negedge clk); #1;
    chk("cap_we3", rf_we3, 0);
    chk("cap_rv0", bus.rsp_valid0, 0);
    chk("cap_A3_hold", rf_A3, 5);
    @(negedge clk); #1;
    chk("resp_rv0", bus.rsp_valid0, 1);
    chk("we_pulses", we_cnt - w0, 1);
    collect();
    issue(1, 0, 4'd0, 32'd0, 4'd5, 4'd5);
    collect();

    // both requesters saturating from reset
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1, 4'd8, 32'h1000, 4'd1, 4'd8);
    drive(1, 1, 4'd9, 32'h2000, 4'd8, 4'd9);
    bus.req_valid0 = 1'b1;
    bus.req_valid1 = 1'b1;
    @(negedge clk); #1;
    chk("rst2_ready0", bus.req_ready0, 0);
    chk("rst2_ready1", bus.req_ready1, 0);
    rst_n = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 20; i++) begin
        #1;
        if ((bus.req_ready0 | bus.req_ready1)
            === 1'b1) break;
        @(negedge clk);
      end
      if ((bus.req_ready0 | bus.req_ready1)
          !== 1'b1) begin
        chk("rr_timeout",
            bus.req_ready0 | bus.req_ready1, 1);
        break;
      end
      chk("rr_onehot",
          bus.req_ready0 & bus.req_ready1, 0);
      chk("rr_grant", {31'd0, bus.req_ready1},
          k % 2);
      g = bus.req_ready1;
      accepted(g);
      if (!g) begin
        n0++;
        drive(0, 1, 4'd8, 32'h1000 + n0,
              4'(1 + n0), 4'd8);
        if (n0 == 3) bus.req_valid0 = 1'b0;
      end else begin
        n1++;
        drive(1, 1, 4'd9, 32'h2000 + n1,
              4'd8, 4'd9);
        if (n1 == 3) bus.req_valid1 = 1'b0;
      end
      #1;
      collect();
    end
    bus.req_valid0 = 1'b0;
    bus.req_valid1 = 1'b0;

    // response back-pressure for 5 cycles
    bus.rsp_ready0 = 1'b0;
    issue(0, 0, 4'd0, 32'd0, 4'd8, 4'd9);
    @(negedge clk); #1;
    @(negedge clk); #1;
    bus.req_valid0 = 1'b1;
    bus.req_valid1 = 1'b1;
    bus.rsp_ready1 = 1'b1;
    w0 = we_cnt;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rv0", bus.rsp_valid0, 1);
      if (sbq.size() > 0) begin
        chk("bp_rd1", bus.rsp_rd1, sbq[0].d1);
        chk("bp_rd2", bus.rsp_rd2, sbq[0].d2);
      end
      chk("bp_ready0", bus.req_ready0, 0);
      chk("bp_ready1", bus.req_ready1, 0);
      @(negedge clk); #1;
    end
    chk("bp_no_we", we_cnt - w0, 0);
    bus.req_valid0 = 1'b0;
    bus.req_valid1 = 1'b0;
    bus.rsp_ready0 = 1'b1;
    collect();

    // reset during CAPTURE of a write
    issue(0, 1, 4'd10, 32'hCAFE, 4'd10, 4'd10);
    @(negedge clk);
    rst_n = 1'b0;
    void'(sbq.pop_back());
    w0 = we_cnt;
    r0 = rv0_cnt;
    @(negedge clk); #1;
    chk("ar_rv0", bus.rsp_valid0, 0);
    chk("ar_we3", rf_we3, 0);
    chk("ar_A3", rf_A3, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("ar_no_we", we_cnt - w0, 0);
    chk("ar_no_rsp", rv0_cnt - r0, 0);
    issue(0, 0, 4'd0, 32'd0, 4'd10, 4'd2);
    collect();

    // register 0 handling
    force_rd1 = 1'b1;
    issue(0, 1, 4'd0, 32'h1234, 4'd0, 4'd4);
    chk("z_we3", rf_we3, {31'd0, !ZERO_EN});
    collect();
    force_rd1 = 1'b0;
    issue(1, 0, 4'd0, 32'd0, 4'd0, 4'd0);
    collect();
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
